// File: rtl/mem_port_arbiter.sv
// Shares one external memory/UART bus port between instruction fetch (IF) and
// data memory (DM), with a DM-starvation guard, bus timeout and pipeline stop.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int TIMEOUT       = 16,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_done_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_done_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          pstop_o,
  output logic          err_o
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_DM, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          err_q, err_d;
  logic          grant_dm_s, grant_if_s;
  logic [DW-1:0] fill_s;

  // A timed-out load/fetch returns all-ones; an ack in the last cycle still wins.
  assign fill_s = mem_ack_i ? mem_rdata_i : {DW{1'b1}};

  // Arbitration: DM wins unless IF is waiting and DM has used up its streak.
  always_comb begin
    grant_dm_s = 1'b0;
    grant_if_s = 1'b0;
    if (dm_req_i && (!if_req_i || (streak_q < STREAK_MAX))) begin
      grant_dm_s = 1'b1;
    end else if (if_req_i) begin
      grant_if_s = 1'b1;
    end else begin
      grant_dm_s = 1'b0;
    end
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d = {TW{1'b0}};
        if (grant_dm_s) begin
          state_d     = S_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (!if_req_i) begin
            streak_d = {SW{1'b0}};
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (grant_if_s) begin
          state_d     = S_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = {DW{1'b0}};
          streak_d    = {SW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_ack_i || (tmo_q == TMO_LAST)) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = ~mem_ack_i;
          if (state_q == S_BUSY_DM) begin
            dm_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
          // Stores never touch the read-data holding registers.
          if (!mem_we_q && (state_q == S_BUSY_DM)) begin
            dm_rdata_d = fill_s;
          end else if (!mem_we_q) begin
            if_rdata_d = fill_s;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tmo_d   = {TW{1'b0}};
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything including read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      streak_q    <= {SW{1'b0}};
      tmo_q       <= {TW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      if_rdata_q  <= {DW{1'b0}};
      dm_rdata_q  <= {DW{1'b0}};
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_done_o   = if_done_q;
  assign dm_done_o   = dm_done_q;
  assign err_o       = err_q;
  // Stall while any request is outstanding and not completing this cycle.
  assign pstop_o     = rst & ((dm_req_i & ~dm_done_q) | (if_req_i & ~if_done_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timestamp-based transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TIMEOUT = 16, MAX_DM_STREAK = 4;
  localparam int NO_ACK = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0, dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0, mem_rdata_i = '0;
  logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_done_o, dm_done_o, mem_req_o, mem_we_o, pstop_o, err_o;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_DM_STREAK(MAX_DM_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .pstop_o(pstop_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Transaction model: owner (0 none, 1 IF, 2 DM), first bus cycle, end cycle (ack/timeout).
  int          m_owner, m_start, m_end, m_streak;
  logic        m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
  int          t, cur_k, checks, errors;
  bit          rand_mode, cur_done_if, cur_done_dm;
  logic        dir_if_req, dir_dm_req, dir_dm_we;
  logic [31:0] dir_if_addr, dir_dm_addr, dir_dm_wdata, fix_rdata;
  int          fix_k, fr_t;
  logic        fr_we;
  logic [31:0] fr_addr, fr_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic bit exp_req();
    return (m_owner != 0) && (t >= m_start) && (m_end < 0);
  endfunction

  function automatic bit exp_done(input int who);
    return (m_owner == who) && (m_end >= 0) && (t == m_end + 1);
  endfunction

  function automatic int pick_k();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return int'($urandom_range(0, 3));
    else if (r == 6) return TIMEOUT - 1;
    else if (r == 7) return TIMEOUT - 2;
    else return NO_ACK;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_start = 0; m_end = -1; m_streak = 0; m_we = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0;
    cur_done_if = 1'b0; cur_done_dm = 1'b0;
  endtask

  // Applies the rules to the inputs sampled at the edge closing cycle t.
  task automatic model_update();
    if (m_owner != 0) begin
      if (m_end < 0) begin
        if (mem_ack_i || (t - m_start == TIMEOUT - 1)) begin
          m_end = t;
          m_err = !mem_ack_i;
          if (!m_we) begin
            if (m_owner == 2) m_dmr = mem_ack_i ? mem_rdata_i : 32'hFFFF_FFFF;
            else              m_ifr = mem_ack_i ? mem_rdata_i : 32'hFFFF_FFFF;
          end
        end
      end else if (t == m_end + 1) begin
        m_owner = 0;
      end
    end else if (dm_req_i && (!if_req_i || m_streak < MAX_DM_STREAK)) begin
      m_owner = 2; m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
      m_start = t + 1; m_end = -1;
      m_streak = if_req_i ? ((m_streak < MAX_DM_STREAK) ? m_streak + 1 : m_streak) : 0;
    end else if (if_req_i) begin
      m_owner = 1; m_we = 1'b0; m_addr = if_addr_i; m_wdata = '0;
      m_start = t + 1; m_end = -1; m_streak = 0;
    end
  endtask

  task automatic check_outputs();
    bit er;
    er = exp_req();
    cur_done_if = exp_done(1);
    cur_done_dm = exp_done(2);
    chk("mem_req", mem_req_o, er);
    if (er) begin
      chk("mem_we", mem_we_o, m_we);
      chk("mem_addr", mem_addr_o, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("if_done", if_done_o, cur_done_if);
    chk("dm_done", dm_done_o, cur_done_dm);
    chk("err", err_o, (cur_done_if | cur_done_dm) & m_err);
    chk("if_rdata", if_rdata_o, m_ifr);
    chk("dm_rdata", dm_rdata_o, m_dmr);
  endtask

  task automatic drive();
    if (rand_mode) begin
      if (!if_req_i || cur_done_if) begin
        if ($urandom_range(0, 3) < (if_req_i ? 3 : 1)) begin
          if_req_i = 1'b1; if_addr_i = $urandom();
        end else if_req_i = 1'b0;
      end
      if (!dm_req_i || cur_done_dm) begin
        if ($urandom_range(0, 3) < (dm_req_i ? 3 : 2)) begin
          dm_req_i = 1'b1; dm_we_i = $urandom_range(0, 1) == 1;
          dm_addr_i = $urandom(); dm_wdata_i = $urandom();
        end else dm_req_i = 1'b0;
      end
    end else begin
      if_req_i = dir_if_req; if_addr_i = dir_if_addr;
      dm_req_i = dir_dm_req; dm_we_i = dir_dm_we; dm_addr_i = dir_dm_addr; dm_wdata_i = dir_dm_wdata;
    end
    if (exp_req()) begin
      if (t == m_start) cur_k = rand_mode ? pick_k() : fix_k;
      mem_ack_i = ((t - m_start) == cur_k);
    end else begin
      mem_ack_i = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
    mem_rdata_i = rand_mode ? $urandom() : fix_rdata;
  endtask

  task automatic tail();
    drive();
    #1;
    chk("pstop", pstop_o, rst & ((dm_req_i & ~cur_done_dm) | (if_req_i & ~cur_done_if)));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_update();
    t++;
    @(negedge clk);
    check_outputs();
    tail();
  endtask

  task automatic wait_done(input bit want_dm, output int done_t, output int req_cyc);
    bit seen;
    seen = 1'b0; done_t = -1; req_cyc = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (mem_req_o) begin
        req_cyc++;
        if (!seen) begin
          seen = 1'b1; fr_t = t; fr_we = mem_we_o; fr_addr = mem_addr_o; fr_wdata = mem_wdata_o;
        end
      end
      if (want_dm ? dm_done_o : if_done_o) begin
        done_t = t;
        break;
      end
    end
    chk("done_seen", done_t >= 0, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, dt, dt2, rc, seq, ncomp, t_rel;
    checks = 0; errors = 0; t = 0; cur_k = 0; rand_mode = 1'b0;
    dir_if_req = 1'b0; dir_dm_req = 1'b0; dir_dm_we = 1'b0;
    dir_if_addr = '0; dir_dm_addr = '0; dir_dm_wdata = '0; fix_rdata = '0; fix_k = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    rst = 1'b1;
    tail();

    // Single load, memory acks one cycle after the request.
    dir_dm_req = 1'b1; dir_dm_we = 1'b0; dir_dm_addr = 32'h40; fix_k = 1; fix_rdata = 32'hDEADBEEF;
    step(); n0 = t;
    wait_done(1'b1, dt, rc);
    chk("lw_req_lat", fr_t - n0, 32'd1);
    chk("lw_addr", fr_addr, 32'h40);
    chk("lw_done_lat", dt - n0, 32'd3);
    chk("lw_rdata", dm_rdata_o, 32'hDEADBEEF);
    chk("lw_err", err_o, 1'b0);
    chk("lw_pstop_done", pstop_o, 1'b0);
    dir_dm_req = 1'b0; step();

    // Load that never gets acked.
    dir_dm_req = 1'b1; dir_dm_addr = 32'h80; fix_k = NO_ACK;
    wait_done(1'b1, dt, rc);
    chk("tmo_req_cycles", rc, 32'd16);
    chk("tmo_err", err_o, 1'b1);
    chk("tmo_rdata", dm_rdata_o, 32'hFFFF_FFFF);
    dir_dm_req = 1'b0; step();

    // Store with zero-wait memory.
    dir_dm_req = 1'b1; dir_dm_we = 1'b1; dir_dm_addr = 32'h44; dir_dm_wdata = 32'h12345678;
    fix_k = 0; fix_rdata = 32'h5555_AAAA;
    step(); n0 = t;
    wait_done(1'b1, dt, rc);
    chk("sw_we", fr_we, 1'b1);
    chk("sw_wdata", fr_wdata, 32'h12345678);
    chk("sw_done_lat", dt - n0, 32'd2);
    chk("sw_rdata_kept", dm_rdata_o, 32'hFFFF_FFFF);
    dir_dm_req = 1'b0; dir_dm_we = 1'b0; step();

    // Ack on the last allowed cycle counts as success.
    dir_dm_req = 1'b1; dir_dm_addr = 32'h84; fix_k = TIMEOUT - 1; fix_rdata = 32'hA5A5_0F0F;
    wait_done(1'b1, dt, rc);
    chk("late_ack_cycles", rc, 32'd16);
    chk("late_ack_err", err_o, 1'b0);
    chk("late_ack_rdata", dm_rdata_o, 32'hA5A5_0F0F);
    dir_dm_req = 1'b0; step();

    // Simultaneous IF fetch and DM store: DM first, store leaves if_rdata alone.
    dir_if_req = 1'b1; dir_if_addr = 32'h100;
    dir_dm_req = 1'b1; dir_dm_we = 1'b1; dir_dm_addr = 32'h48; dir_dm_wdata = 32'hCAFE0001;
    fix_k = 0; fix_rdata = 32'h0BADF00D;
    wait_done(1'b1, dt, rc);
    chk("both_dm_first", if_done_o, 1'b0);
    chk("both_if_rdata_kept", if_rdata_o, 32'h0);
    chk("both_dm_rdata_kept", dm_rdata_o, 32'hA5A5_0F0F);
    dir_dm_req = 1'b0; dir_dm_we = 1'b0;
    wait_done(1'b0, dt2, rc);
    chk("both_if_gap", dt2 - dt, 32'd3);
    chk("both_if_rdata", if_rdata_o, 32'h0BADF00D);
    dir_if_req = 1'b0; step();

    // Starvation guard: both held, DM back-to-back -> D D D D I D.
    dir_if_req = 1'b1; dir_dm_req = 1'b1; fix_k = 0;
    seq = 0; ncomp = 0;
    for (int n = 0; n < 60 && ncomp < 6; n++) begin
      step();
      if (dm_done_o || if_done_o) begin
        seq = (seq << 1) | int'(dm_done_o);
        ncomp++;
      end
    end
    chk("starve_order", seq, 32'd61);
    dir_if_req = 1'b0; dir_dm_req = 1'b0;
    repeat (3) step();

    // Reset in the middle of a DM transaction.
    dir_dm_req = 1'b1; dir_dm_we = 1'b0; dir_dm_addr = 32'h200; fix_k = NO_ACK;
    for (int n = 0; n < 10 && !mem_req_o; n++) step();
    chk("rst_mid_busy", mem_req_o, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_req_async", mem_req_o, 1'b0);
    chk("rst_mid_pstop", pstop_o, 1'b0);
    model_reset();
    @(posedge clk); t++;
    @(negedge clk);
    check_outputs();
    fix_k = 0; rst = 1'b1;
    tail(); t_rel = t;
    wait_done(1'b1, dt, rc);
    chk("rst_regrant_lat", fr_t - t_rel, 32'd1);
    chk("rst_regrant_lat_done", dt - t_rel, 32'd2);
    dir_dm_req = 1'b0; step();

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    dir_if_req = 1'b0; dir_dm_req = 1'b0; fix_k = 0;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
